spi_txn_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one SPI_mnrch master between up to four requesters.
- Requesters include A2D_intf-style sensor readers and the inertial interface.
- Each requester presents a 16-bit command. The arbiter grants the bus, issues `snd`, waits for `done`, returns `resp` and enforces a minimum idle gap between frames.
- A lock input lets a requester keep the bus for back-to-back frames, for example the A2D convert-then-read pair.

---
 rtl/spi_txn_arb.sv | 145 ++++++++++++++
 tb/tb_spi_txn_arb.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_arb.sv
// spi_txn_arb: round-robin arbiter/sequencer sharing one SPI master among NREQ requesters.
// Define SPI_ARB_TIMEOUT_EN to add a 16-bit per-frame watchdog that forces completion with err.
module spi_txn_arb #(
   parameter int NREQ = 2,
   parameter int GAP  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req,
   input  logic [16*NREQ-1:0]  req_cmd,
   input  logic [NREQ-1:0]     lock,
   output logic [NREQ-1:0]     gnt,
   output logic [NREQ-1:0]     rdy,
   output logic [15:0]         rsp,
   output logic                err,
   output logic                snd,
   output logic [15:0]         cmd,
   input  logic                done,
   input  logic [15:0]         resp,
   output logic                busy
);

   localparam int IW = $clog2(NREQ);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DONE, S_GAP} state_t;

   state_t          state;
   logic [IW-1:0]   last;
   logic [IW-1:0]   owner;
   logic            locked;
   logic [7:0]      gap_cnt;
   logic            pick_valid;
   logic [IW-1:0]   pick_idx;
   logic [IW-1:0]   cand;

`ifdef SPI_ARB_TIMEOUT_EN
   logic [15:0]     wdog;
   logic            err_q;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign busy = (state != S_IDLE);

   // Round-robin scan starting just after the previous winner.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IW'((int'(last) + k) % NREQ);
         if (!pick_valid && req[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         gnt     <= '0;
         rdy     <= '0;
         rsp     <= '0;
         snd     <= 1'b0;
         cmd     <= '0;
         gap_cnt <= '0;
         last    <= IW'(NREQ - 1);
         owner   <= '0;
         locked  <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
         err_q   <= 1'b0;
         wdog    <= '0;
`endif
      end else begin
         snd <= 1'b0;
         rdy <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
         err_q <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (locked && req[owner]) begin
                  cmd   <= req_cmd[16*int'(owner) +: 16];
                  snd   <= 1'b1;
                  state <= S_ISSUE;
               end else begin
                  // A lapsed lock is dropped and arbitration happens in the same cycle.
                  locked <= 1'b0;
                  gnt    <= '0;
                  if (pick_valid) begin
                     gnt[pick_idx] <= 1'b1;
                     cmd           <= req_cmd[16*int'(pick_idx) +: 16];
                     last          <= pick_idx;
                     owner         <= pick_idx;
                     snd           <= 1'b1;
                     state         <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               state <= S_WAIT_DONE;
`ifdef SPI_ARB_TIMEOUT_EN
               wdog  <= '0;
`endif
            end
            S_WAIT_DONE: begin
               if (done) begin
                  rsp        <= resp;
                  rdy[owner] <= 1'b1;
                  locked     <= lock[owner];
                  if (!lock[owner]) begin
                     gnt <= '0;
                  end
                  gap_cnt    <= 8'(GAP - 1);
                  state      <= S_GAP;
               end
`ifdef SPI_ARB_TIMEOUT_EN
               else if (wdog == 16'hFFFE) begin
                  rsp        <= 16'hDEAD;
                  rdy[owner] <= 1'b1;
                  err_q      <= 1'b1;
                  locked     <= 1'b0;
                  gnt        <= '0;
                  gap_cnt    <= 8'(GAP - 1);
                  state      <= S_GAP;
               end else begin
                  wdog <= wdog + 16'd1;
               end
`endif
            end
            S_GAP: begin
               if (gap_cnt == 8'd0) begin
                  state <= S_IDLE;
               end else begin
                  gap_cnt <= gap_cnt - 8'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_txn_arb.sv
// tb_spi_txn_arb: self-checking bench for spi_txn_arb with NREQ=2, GAP=4.
// Cycle table, hand-written corner sequences and a randomized run against a frame-level model.
`timescale 1ns/1ps
module tb_spi_txn_arb;

   localparam int NREQ = 2;
   localparam int GAP  = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req;
   logic [16*NREQ-1:0]  req_cmd;
   logic [NREQ-1:0]     lock;
   logic [NREQ-1:0]     gnt;
   logic [NREQ-1:0]     rdy;
   logic [15:0]         rsp;
   logic                err;
   logic                snd;
   logic [15:0]         cmd;
   logic                done;
   logic [15:0]         resp;
   logic                busy;

   int checks = 0;
   int passes = 0;
   int cur    = 0;

   spi_txn_arb #(.NREQ(NREQ), .GAP(GAP)) dut (
      .clk(clk), .rst(rst), .req(req), .req_cmd(req_cmd), .lock(lock),
      .gnt(gnt), .rdy(rdy), .rsp(rsp), .err(err), .snd(snd), .cmd(cmd),
      .done(done), .resp(resp), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [1:0]  req;
      logic [1:0]  lock;
      logic        done;
      logic [15:0] resp;
      logic [1:0]  gnt;
      logic [1:0]  rdy;
      logic        snd;
      logic        busy;
      logic [15:0] cmd;
      logic [15:0] rsp;
   } vec_t;

   vec_t vecs[$];

   task automatic tick();
      @(posedge clk);
      #1;
      cur++;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cur);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      rst  = v.rst;
      req  = v.req;
      lock = v.lock;
      done = v.done;
      resp = v.resp;
   endtask

   task automatic addVec(input logic r, input logic [1:0] rq, input logic [1:0] lk, input logic dn,
                         input logic [15:0] rs, input logic [1:0] eg, input logic [1:0] er,
                         input logic es, input logic eb, input logic [15:0] ec, input logic [15:0] ersp);
      vec_t v;
      v.rst = r;  v.req = rq; v.lock = lk; v.done = dn; v.resp = rs;
      v.gnt = eg; v.rdy = er; v.snd = es;  v.busy = eb; v.cmd = ec; v.rsp = ersp;
      vecs.push_back(v);
   endtask

   task automatic doReset();
      rst  = 1'b1;
      req  = '0;
      lock = '0;
      done = 1'b0;
      resp = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic waitSnd(input int budget, output bit seen);
      seen = 1'b0;
      for (int n = 0; n < budget; n++) begin
         tick();
         if (snd) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   function automatic int rrPick(input int lastIdx, input logic [NREQ-1:0] r);
      for (int k = 1; k <= NREQ; k++) begin
         int i;
         i = (lastIdx + k) % NREQ;
         if (((r >> i) & 1) != 0) return i;
      end
      return 0;
   endfunction

   initial begin
      #5000000;
      $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      bit              seen;
      int              done_step;
      int              n;
      int              free_at, done_at, rdy_at, owner_m, model_last, w;
      bit              inflight, exp_snd;
      logic [NREQ-1:0] req_prev, exp_rdy;
      logic [15:0]     exp_resp;
      logic [15:0]     cmds[NREQ];

      rst = 1'b1; req = '0; lock = '0; done = 1'b0; resp = '0;
      req_cmd = {16'h1100, 16'h0800};

      // rst req lock done resp | gnt rdy snd busy cmd rsp
      addVec(1, 2'b00, 2'b00, 0, 16'h0000, 2'b00, 2'b00, 0, 0, 16'h0000, 16'h0000);
      addVec(0, 2'b01, 2'b00, 0, 16'h0000, 2'b01, 2'b00, 1, 1, 16'h0800, 16'h0000);
      addVec(0, 2'b01, 2'b00, 0, 16'h0000, 2'b01, 2'b00, 0, 1, 16'h0800, 16'h0000);
      addVec(0, 2'b01, 2'b00, 1, 16'h0ABC, 2'b00, 2'b01, 0, 1, 16'h0800, 16'h0ABC);
      for (int i = 0; i < 3; i++)
         addVec(0, 2'b00, 2'b00, 0, 16'h0000, 2'b00, 2'b00, 0, 1, 16'h0800, 16'h0ABC);
      addVec(0, 2'b00, 2'b00, 0, 16'h0000, 2'b00, 2'b00, 0, 0, 16'h0800, 16'h0ABC);
      addVec(0, 2'b01, 2'b01, 0, 16'h0000, 2'b01, 2'b00, 1, 1, 16'h0800, 16'h0ABC);
      addVec(0, 2'b11, 2'b01, 0, 16'h0000, 2'b01, 2'b00, 0, 1, 16'h0800, 16'h0ABC);
      addVec(0, 2'b11, 2'b01, 1, 16'h1111, 2'b01, 2'b01, 0, 1, 16'h0800, 16'h1111);
      for (int i = 0; i < 3; i++)
         addVec(0, 2'b11, 2'b01, 0, 16'h0000, 2'b01, 2'b00, 0, 1, 16'h0800, 16'h1111);
      addVec(0, 2'b11, 2'b01, 0, 16'h0000, 2'b01, 2'b00, 0, 0, 16'h0800, 16'h1111);
      addVec(0, 2'b11, 2'b01, 0, 16'h0000, 2'b01, 2'b00, 1, 1, 16'h0800, 16'h1111);
      addVec(0, 2'b11, 2'b00, 0, 16'h0000, 2'b01, 2'b00, 0, 1, 16'h0800, 16'h1111);
      addVec(0, 2'b11, 2'b00, 1, 16'h2222, 2'b00, 2'b01, 0, 1, 16'h0800, 16'h2222);
      for (int i = 0; i < 3; i++)
         addVec(0, 2'b10, 2'b00, 0, 16'h0000, 2'b00, 2'b00, 0, 1, 16'h0800, 16'h2222);
      addVec(0, 2'b10, 2'b00, 0, 16'h0000, 2'b00, 2'b00, 0, 0, 16'h0800, 16'h2222);
      addVec(0, 2'b10, 2'b00, 0, 16'h0000, 2'b10, 2'b00, 1, 1, 16'h1100, 16'h2222);
      addVec(0, 2'b10, 2'b00, 0, 16'h0000, 2'b10, 2'b00, 0, 1, 16'h1100, 16'h2222);
      addVec(0, 2'b10, 2'b10, 1, 16'h3333, 2'b10, 2'b10, 0, 1, 16'h1100, 16'h3333);
      for (int i = 0; i < 3; i++)
         addVec(0, 2'b01, 2'b00, 0, 16'h0000, 2'b10, 2'b00, 0, 1, 16'h1100, 16'h3333);
      addVec(0, 2'b01, 2'b00, 0, 16'h0000, 2'b10, 2'b00, 0, 0, 16'h1100, 16'h3333);
      addVec(0, 2'b01, 2'b00, 0, 16'h0000, 2'b01, 2'b00, 1, 1, 16'h0800, 16'h3333);
      addVec(0, 2'b01, 2'b00, 0, 16'h0000, 2'b01, 2'b00, 0, 1, 16'h0800, 16'h3333);
      addVec(0, 2'b01, 2'b00, 1, 16'h4444, 2'b00, 2'b01, 0, 1, 16'h0800, 16'h4444);
      addVec(0, 2'b00, 2'b00, 0, 16'h0000, 2'b00, 2'b00, 0, 1, 16'h0800, 16'h4444);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         tick();
         checkOutput($sformatf("tbl%0d_gnt", i),  32'(gnt),  32'(vecs[i].gnt));
         checkOutput($sformatf("tbl%0d_rdy", i),  32'(rdy),  32'(vecs[i].rdy));
         checkOutput($sformatf("tbl%0d_snd", i),  32'(snd),  32'(vecs[i].snd));
         checkOutput($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
         checkOutput($sformatf("tbl%0d_cmd", i),  32'(cmd),  32'(vecs[i].cmd));
         checkOutput($sformatf("tbl%0d_rsp", i),  32'(rsp),  32'(vecs[i].rsp));
         checkOutput($sformatf("tbl%0d_err", i),  32'(err),  32'd0);
      end

      // Both requesters held: grants alternate and each snd lands GAP+2 cycles after done.
      doReset();
      req = 2'b11;
      done_step = 0;
      for (int f = 0; f < 4; f++) begin
         waitSnd(30, seen);
         checkOutput("alt_snd_seen", 32'(seen), 32'd1);
         checkOutput("alt_gnt", 32'(gnt), (f % 2 == 0) ? 32'd1 : 32'd2);
         if (f > 0) checkOutput("alt_spacing", 32'(cur - done_step), 32'(GAP + 2));
         tick();
         done = 1'b1;
         resp = 16'h0A00 + 16'(f);
         done_step = cur;
         tick();
         done = 1'b0;
         checkOutput("alt_rdy", 32'(rdy), (f % 2 == 0) ? 32'd1 : 32'd2);
         checkOutput("alt_rsp", 32'(rsp), 32'h0A00 + 32'(f));
      end
      req = '0;

      // Reset during WAIT_DONE, then a stray done in IDLE must be ignored.
      doReset();
      req = 2'b01;
      waitSnd(5, seen);
      checkOutput("rstmid_snd_seen", 32'(seen), 32'd1);
      tick();
      checkOutput("rstmid_busy_pre", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req = '0;
      tick();
      done = 1'b1;
      resp = 16'hBEEF;
      tick();
      done = 1'b0;
      checkOutput("rstmid_rdy", 32'(rdy), 32'd0);
      checkOutput("rstmid_rsp", 32'(rsp), 32'd0);
      checkOutput("rstmid_busy", 32'(busy), 32'd0);
      checkOutput("rstmid_gnt", 32'(gnt), 32'd0);
      tick();
      checkOutput("rstmid_rdy2", 32'(rdy), 32'd0);
      checkOutput("rstmid_rsp2", 32'(rsp), 32'd0);

      // Owner drops req mid-frame: the frame still completes.
      doReset();
      req_cmd = {16'h2BCD, 16'h1A00};
      req = 2'b10;
      waitSnd(5, seen);
      checkOutput("drop_snd_seen", 32'(seen), 32'd1);
      checkOutput("drop_gnt", 32'(gnt), 32'd2);
      checkOutput("drop_cmd", 32'(cmd), 32'h2BCD);
      tick();
      req = '0;
      tick();
      done = 1'b1;
      resp = 16'h0C0C;
      tick();
      done = 1'b0;
      checkOutput("drop_rdy", 32'(rdy), 32'd2);
      checkOutput("drop_rsp", 32'(rsp), 32'h0C0C);
      repeat (GAP) tick();
      checkOutput("drop_busy", 32'(busy), 32'd0);
      checkOutput("drop_gnt_clr", 32'(gnt), 32'd0);

`ifdef SPI_ARB_TIMEOUT_EN
      // done withheld: watchdog forces completion with err and 16'hDEAD.
      doReset();
      req = 2'b01;
      waitSnd(5, seen);
      checkOutput("to_snd_seen", 32'(seen), 32'd1);
      req = 2'b11;
      n = 0;
      while (rdy == '0 && n < 70000) begin
         tick();
         n++;
      end
      checkOutput("to_fired", 32'(n < 70000), 32'd1);
      checkOutput("to_latency", 32'(n >= 65535 && n <= 65537), 32'd1);
      checkOutput("to_rdy", 32'(rdy), 32'd1);
      checkOutput("to_err", 32'(err), 32'd1);
      checkOutput("to_rsp", 32'(rsp), 32'hDEAD);
      req = 2'b10;
      done = 1'b1;
      resp = 16'h1234;
      tick();
      done = 1'b0;
      checkOutput("to_late_rdy", 32'(rdy), 32'd0);
      checkOutput("to_late_err", 32'(err), 32'd0);
      checkOutput("to_late_rsp", 32'(rsp), 32'hDEAD);
      waitSnd(20, seen);
      checkOutput("to_next_seen", 32'(seen), 32'd1);
      checkOutput("to_next_gnt", 32'(gnt), 32'd2);
      tick();
      done = 1'b1;
      resp = 16'h5555;
      tick();
      done = 1'b0;
      req = '0;
`endif

      // Randomized traffic against a frame-level model: bus free time, round-robin winner, responses.
      doReset();
      free_at    = cur + 1;
      done_at    = -1;
      rdy_at     = -1;
      owner_m    = 0;
      model_last = NREQ - 1;
      inflight   = 1'b0;
      exp_resp   = '0;
      req_prev   = '0;
      for (int i = 0; i < NREQ; i++) cmds[i] = '0;
      for (int s = 0; s < 800; s++) begin
         tick();
         exp_snd = !inflight && (cur >= free_at) && (req_prev != '0);
         checkOutput("rnd_snd", 32'(snd), 32'(exp_snd));
         exp_rdy = (cur == rdy_at) ? NREQ'(1 << owner_m) : '0;
         checkOutput("rnd_rdy", 32'(rdy), 32'(exp_rdy));
         if (cur == rdy_at) checkOutput("rnd_rsp", 32'(rsp), 32'(exp_resp));
         if (exp_snd) begin
            w = rrPick(model_last, req_prev);
            checkOutput("rnd_gnt", 32'(gnt), 32'(1 << w));
            checkOutput("rnd_cmd", 32'(cmd), 32'(cmds[w]));
            model_last = w;
            owner_m    = w;
            inflight   = 1'b1;
            done_at    = cur + int'($urandom_range(1, 6));
         end
         done = 1'b0;
         if (inflight && cur == done_at) begin
            done     = 1'b1;
            resp     = 16'($urandom);
            exp_resp = resp;
            inflight = 1'b0;
            free_at  = cur + GAP + 2;
            rdy_at   = cur + 1;
         end
         for (int i = 0; i < NREQ; i++) begin
            if (rdy[i]) begin
               req[i] = 1'b0;
            end else if (!req[i] && $urandom_range(0, 2) == 0) begin
               cmds[i] = 16'($urandom);
               req_cmd[16*i +: 16] = cmds[i];
               req[i] = 1'b1;
            end
         end
         req_prev = req;
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
